prbs_checker: RTL and testbench
===============================

// Module: prbs_checker
// PURPOSE
//  Downstream consumer of the N-bit LFSR state word (q). It predicts each next word
//  with the same Galois polynomial and self-synchronises on the incoming stream.
//  Reports lock, counts mismatches, and drops lock after repeated errors.
//  Sits between the LFSR generator and the test/status readout logic.
// PARAMETERS
//  N         26            LFSR word width
//  TAP_MASK  26'h0000046   bit i=1 -> pred[i] = din[i-1]^din[N-1]; bit 0 ignored
//  LOCK_CNT  4             consecutive matches required to enter LOCKED (>=1)
//  LOSS_CNT  3             consecutive mismatches in LOCKED that force HUNT (>=1)
//  CW        16            error counter width
// PORTS
//  clk        in   1    single clock, rising edge
//  r          in   1    reset: asynchronous, active-high
//  din        in   N    LFSR state word (connects to generator q)
//  din_valid  in   1    din is sampled only when 1
//  err_clr    in   1    synchronous clear of err_count
//  locked     out  1    1 while FSM is in LOCKED
//  err_pulse  out  1    1-cycle strobe per mismatch counted in LOCKED
//  err_count  out  CW   saturating mismatch count (LOCKED only)
//  stuck      out  1    all-zero word seen (only with PRBS_CHK_STUCK_EN, else tied 0)
// BEHAVIOUR
//  - Reset (async, r=1): state=HUNT, pred=0, match/miss counters=0, locked=0,
//    err_pulse=0, err_count=0, stuck=0. Asserting r mid-run aborts immediately.
//  - Prediction: pred[0]=din[N-1]; pred[i]=din[i-1]^(TAP_MASK[i]&din[N-1]), i>=1.
//    pred is registered on every valid cycle, whatever the state.
//  - Invalid cycles: all state, counters, and pred hold. err_pulse=0.
//  - States:
//    HUNT: first valid word loads pred only, with no compare. Next state is SYNC, match=0.
//    SYNC: on a valid word, if din==pred then match++. When match reaches LOCK_CNT,
//      go to LOCKED. On a mismatch, match=0 and stay in SYNC (pred reloads from din).
//    LOCKED: on a valid mismatch, err_pulse=1, err_count++ (saturates at all-ones), and miss++.
//      When miss reaches LOSS_CNT, go to HUNT. On a valid match, miss=0.
//  - Outputs are registered. locked/err_pulse/err_count update the cycle after
//    the deciding valid word (latency 1).
//  - err_clr: err_count=0 the next cycle. If err_clr coincides with a counted error,
//    the count becomes 1. err_clr does not affect state.
//  - Errors in HUNT/SYNC are never counted. Transition LOCKED->HUNT clears miss.
// CONFIGURATION
//  PRBS_CHK_STUCK_EN defined: a valid din==0 (LFSR lockup) sets stuck=1
//    (sticky until r) and forces state to HUNT the next cycle from any state.
//    A zero word is not counted as an error.
//  Not defined: stuck is constant 0, and a zero word is treated like any other word.
// STRUCTURE
//  prbs_pkg: typedef enum logic [1:0] {HUNT, SYNC, LOCKED} prbs_state_t;
//    default tap mask constant PRBS26_TAPS = 26'h0000046.
//  Sub-module prbs_next #(N,TAP_MASK): combinational din -> pred function.
//    Reusable by a future generator model.
// TESTING
//  1 Reset: r=1 with din toggling -> locked=0, err_count=0, err_pulse=0; hold after r=0.
//  2 Prediction: valid 26'h2000000 then 26'h0000047 in SYNC -> counted as a match.
//    26'h0000001 -> pred 26'h0000002.
//  3 Lock: feed a clean sequence seeded with 26'h0000001 -> locked=1 on the cycle after
//    the 5th valid word (1 load + LOCK_CNT=4 matches). Gaps in din_valid do not break the count.
//  4 Errors: once LOCKED, flip bit 3 in one word -> err_pulse once, err_count=1, locked stays 1.
//    Then 3 consecutive bad words -> err_count=4, locked=0, state HUNT.
//  5 Saturation/clear: CW=2, inject 5 errors -> err_count=3. Apply err_clr alone -> 0.
//    Apply err_clr together with an error -> 1.
//  6 PRBS_CHK_STUCK_EN: in LOCKED, feed din=0 -> stuck=1, locked=0 next cycle,
//    err_count unchanged. Without the macro, the same stimulus is a normal mismatch.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared types and constants for the PRBS checker and future generator models.
package prbs_pkg;

    localparam logic [25:0] PRBS26_TAPS = 26'h0000046;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } prbs_state_t;

endpackage

// File: rtl/prbs_next.sv
// Combinational Galois LFSR step: din -> predicted next state word.
module prbs_next
    import prbs_pkg::*;
#(
    parameter int             N        = 26,
    parameter logic [N-1:0]   TAP_MASK = PRBS26_TAPS
) (
    input  logic [N-1:0] din,
    output logic [N-1:0] pred
);

    // Rotate left, then fold the feedback bit into the tapped positions (bit 0 tap is meaningless).
    assign pred = {din[N-2:0], din[N-1]} ^ ({TAP_MASK[N-1:1], 1'b0} & {N{din[N-1]}});

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: HUNT -> SYNC -> LOCKED, error strobe and saturating count.
// Optional lockup detection on an all-zero word is enabled by defining PRBS_CHK_STUCK_EN.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int           N        = 26,
    parameter logic [N-1:0] TAP_MASK = PRBS26_TAPS,
    parameter int           LOCK_CNT = 4,
    parameter int           LOSS_CNT = 3,
    parameter int           CW       = 16
) (
    input  logic          clk,
    input  logic          r,
    input  logic [N-1:0]  din,
    input  logic          din_valid,
    input  logic          err_clr,
    output logic          locked,
    output logic          err_pulse,
    output logic [CW-1:0] err_count,
    output logic          stuck
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_CNT + 1);

    prbs_state_t   state, state_n;
    logic [N-1:0]  pred, pred_next;
    logic [MW-1:0] match, match_n;
    logic [LW-1:0] miss, miss_n;
    logic          err_hit;
    logic          zero_hit;
    logic [CW-1:0] err_count_n;

    prbs_next #(.N(N), .TAP_MASK(TAP_MASK)) u_next (
        .din  (din),
        .pred (pred_next)
    );

`ifdef PRBS_CHK_STUCK_EN
    assign zero_hit = din_valid && (din == '0);
`else
    assign zero_hit = 1'b0;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_n = state;
        match_n = match;
        miss_n  = miss;
        err_hit = 1'b0;
        if (zero_hit) begin
            state_n = HUNT;
            match_n = '0;
            miss_n  = '0;
        end else if (din_valid) begin
            case (state)
                HUNT: begin
                    state_n = SYNC;
                    match_n = '0;
                end
                SYNC: begin
                    if (din == pred) begin
                        if (match == MW'(LOCK_CNT - 1)) begin
                            state_n = LOCKED;
                            match_n = '0;
                            miss_n  = '0;
                        end else begin
                            match_n = match + MW'(1);
                        end
                    end else begin
                        match_n = '0;
                    end
                end
                LOCKED: begin
                    if (din != pred) begin
                        err_hit = 1'b1;
                        if (miss == LW'(LOSS_CNT - 1)) begin
                            state_n = HUNT;
                            miss_n  = '0;
                        end else begin
                            miss_n = miss + LW'(1);
                        end
                    end else begin
                        miss_n = '0;
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    // A clear that lands on a counted error leaves exactly that one error in the count.
    always_comb begin
        err_count_n = err_count;
        if (err_clr)
            err_count_n = err_hit ? CW'(1) : '0;
        else if (err_hit && (err_count != '1))
            err_count_n = err_count + CW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state     <= HUNT;
            pred      <= '0;
            match     <= '0;
            miss      <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_n;
            match     <= match_n;
            miss      <= miss_n;
            if (din_valid)
                pred <= pred_next;
            locked    <= (state_n == LOCKED);
            err_pulse <= err_hit;
            err_count <= err_count_n;
        end
    end

`ifdef PRBS_CHK_STUCK_EN
    always_ff @(posedge clk or posedge r) begin
        if (r)
            stuck <= 1'b0;
        else if (zero_hit)
            stuck <= 1'b1;
    end
`else
    assign stuck = 1'b0;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: a CW=16 instance and a CW=2 instance share the stimulus.
module tb_prbs_checker;

    logic        clk = 1'b0;
    logic        r;
    logic [25:0] din;
    logic        din_valid;
    logic        err_clr;

    logic        locked, err_pulse, stuck;
    logic [15:0] err_count;
    logic        s_locked, s_err_pulse, s_stuck;
    logic [1:0]  s_err_count;

    int n_vec = 0;
    int n_err = 0;

    prbs_checker #(.CW(16)) dut (
        .clk       (clk),
        .r         (r),
        .din       (din),
        .din_valid (din_valid),
        .err_clr   (err_clr),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .stuck     (stuck)
    );

    prbs_checker #(.CW(2)) dut_sat (
        .clk       (clk),
        .r         (r),
        .din       (din),
        .din_valid (din_valid),
        .err_clr   (err_clr),
        .locked    (s_locked),
        .err_pulse (s_err_pulse),
        .err_count (s_err_count),
        .stuck     (s_stuck)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic [25:0] d, input logic clr);
        @(negedge clk);
        din_valid = v;
        din       = d;
        err_clr   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        r         = 1'b1;
        din_valid = 1'b0;
        err_clr   = 1'b0;
        @(negedge clk);
        r = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with din toggling
        r         = 1'b1;
        din_valid = 1'b1;
        err_clr   = 1'b0;
        din       = 26'h2000000;
        @(posedge clk); #1;
        din = 26'h0000047;
        @(posedge clk); #1;
        check("rst_locked", locked, 0);
        check("rst_err_count", err_count, 0);
        check("rst_err_pulse", err_pulse, 0);
        check("rst_stuck", stuck, 0);
        check("rst_sat_count", s_err_count, 0);
        @(negedge clk);
        r         = 1'b0;
        din_valid = 1'b0;
        step(1'b0, 26'h3ffffff, 1'b0);
        step(1'b0, 26'h0000000, 1'b0);
        check("hold_locked", locked, 0);
        check("hold_err_count", err_count, 0);

        // Prediction across the feedback bit: 2000000 -> 47, then clean shifts
        step(1'b1, 26'h2000000, 1'b0);
        step(1'b1, 26'h0000047, 1'b0);
        step(1'b1, 26'h000008e, 1'b0);
        step(1'b1, 26'h000011c, 1'b0);
        check("pred_locked_early", locked, 0);
        step(1'b1, 26'h0000238, 1'b0);
        check("pred_locked", locked, 1);
        check("pred_no_err", err_pulse, 0);

        // A mismatch in SYNC restarts the match count
        pulse_reset();
        check("rst2_locked", locked, 0);
        step(1'b1, 26'h0000001, 1'b0);
        step(1'b1, 26'h0000002, 1'b0);
        step(1'b1, 26'h0000004, 1'b0);
        step(1'b1, 26'h0000009, 1'b0);
        step(1'b1, 26'h0000012, 1'b0);
        step(1'b1, 26'h0000024, 1'b0);
        step(1'b1, 26'h0000048, 1'b0);
        check("sync_miss_locked_early", locked, 0);
        step(1'b1, 26'h0000090, 1'b0);
        check("sync_miss_locked", locked, 1);
        check("sync_miss_no_count", err_count, 0);

        // Lock from seed 1 with gaps in din_valid
        pulse_reset();
        step(1'b1, 26'h0000001, 1'b0);
        step(1'b0, 26'h3ffffff, 1'b0);
        step(1'b1, 26'h0000002, 1'b0);
        step(1'b0, 26'h0000000, 1'b0);
        step(1'b0, 26'h1234567, 1'b0);
        step(1'b1, 26'h0000004, 1'b0);
        step(1'b1, 26'h0000008, 1'b0);
        check("lock_4th_word", locked, 0);
        step(1'b0, 26'h0000010, 1'b0);
        check("lock_gap", locked, 0);
        step(1'b1, 26'h0000010, 1'b0);
        check("lock_5th_word", locked, 1);
        step(1'b0, 26'h0000000, 1'b0);
        check("lock_hold", locked, 1);

        // Single bit-3 error while LOCKED (pred = 0x20)
        step(1'b1, 26'h0000028, 1'b0);
        check("err1_pulse", err_pulse, 1);
        check("err1_count", err_count, 1);
        check("err1_locked", locked, 1);
        step(1'b0, 26'h0000000, 1'b0);
        check("err1_pulse_once", err_pulse, 0);
        check("err1_count_hold", err_count, 1);
        step(1'b1, 26'h0000050, 1'b0);
        check("good_pulse", err_pulse, 0);
        check("good_locked", locked, 1);

        // Three consecutive bad words drop lock
        step(1'b1, 26'h00000a8, 1'b0);
        check("bad1_count", err_count, 2);
        check("bad1_locked", locked, 1);
        step(1'b1, 26'h0000158, 1'b0);
        check("bad2_count", err_count, 3);
        check("bad2_locked", locked, 1);
        check("sat_count_3", s_err_count, 3);
        step(1'b1, 26'h00002b8, 1'b0);
        check("bad3_count", err_count, 4);
        check("bad3_locked", locked, 0);
        check("bad3_pulse", err_pulse, 1);
        check("sat_count_hold", s_err_count, 3);
        step(1'b1, 26'h0000005, 1'b0);
        check("hunt_no_pulse", err_pulse, 0);
        check("hunt_no_count", err_count, 4);

        // err_clr alone, then err_clr together with a counted error
        step(1'b0, 26'h0000000, 1'b1);
        check("clr_count", err_count, 0);
        check("clr_sat_count", s_err_count, 0);
        step(1'b1, 26'h0000001, 1'b0);
        step(1'b1, 26'h0000002, 1'b0);
        step(1'b1, 26'h0000004, 1'b0);
        step(1'b1, 26'h0000008, 1'b0);
        step(1'b1, 26'h0000010, 1'b0);
        check("relock", locked, 1);
        step(1'b1, 26'h0000028, 1'b1);
        check("clr_err_count", err_count, 1);
        check("clr_err_sat_count", s_err_count, 1);
        check("clr_err_pulse", err_pulse, 1);
        check("clr_err_locked", locked, 1);

        // All-zero word while LOCKED (pred = 0x50, one miss pending)
        step(1'b1, 26'h0000000, 1'b0);
`ifdef PRBS_CHK_STUCK_EN
        check("zero_stuck", stuck, 1);
        check("zero_locked", locked, 0);
        check("zero_count", err_count, 1);
        check("zero_pulse", err_pulse, 0);
        step(1'b0, 26'h0000000, 1'b0);
        check("zero_stuck_sticky", stuck, 1);
`else
        check("zero_stuck", stuck, 0);
        check("zero_locked", locked, 1);
        check("zero_count", err_count, 2);
        check("zero_pulse", err_pulse, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
